jtag_dr_hs: RTL and testbench

JTAG_DR_HS -- requirements
Module: jtag_dr_hs

---
 rtl/jtag_dr_pkg.sv | 19 +
 rtl/jtag_sync.sv | 25 ++
 rtl/jtag_dr.sv | 174 +++++++++++++++++
 tb/tb_jtag_dr_hs.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dr_pkg.sv
// Shared definitions for the handshaked JTAG data register: status bit
// layout of the scan register, per-channel state encoding and sizing helper.
package jtag_dr_pkg;

    localparam int STAT_BITS = 2;
    localparam int STAT_BUSY = 0;
    localparam int STAT_OVR  = 1;

    typedef enum logic [0:0] {
        CH_IDLE = 1'b0,
        CH_PEND = 1'b1
    } ch_state_e;

    // Width of a channel index; a single channel still gets a 1-bit select.
    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/jtag_sync.sv
// Two-flop synchroniser bringing the TDI level into the clk_i domain.
module jtag_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/jtag_dr.sv
// JTAG data register shared by NCH channels. The scan register carries the
// payload plus two status bits (busy, overrun) so the debugger can see on
// capture whether the previous update has been consumed. Each channel runs
// a small IDLE/PEND handshake with its consumer.
module jtag_dr_hs
    import jtag_dr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SYNC  = 1,
    localparam int SW   = sel_width(NCH)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    input  logic                        capture_dr_i,
    input  logic                        shift_dr_i,
    input  logic                        update_dr_i,
    input  logic [SW-1:0]               sel_i,
    input  logic                        scan_in_i,
    output logic                        scan_out_o,
    input  logic [NCH-1:0][WIDTH-1:0]   cap_data_i,
    output logic [WIDTH-1:0]            upd_data_o,
    output logic [NCH-1:0]              upd_valid_o,
    input  logic [NCH-1:0]              upd_ready_i
);

    localparam int          SRW   = WIDTH + STAT_BITS;
    localparam logic [SW:0] NCH_L = (SW + 1)'(NCH);

    logic                  tdi_s;
    logic                  sel_ok_s;
    logic                  do_cap_s;
    logic                  do_shift_s;
    logic                  do_upd_s;
    logic [NCH-1:0]        sel_hot_s;
    logic [WIDTH-1:0]      cap_sel_s;
    logic                  ovr_sel_s;
    logic                  vld_sel_s;

    logic [NCH-1:0]        upd_ch_s;
    logic [NCH-1:0]        accept_s;
    logic [NCH-1:0]        ovr_set_s;

    ch_state_e             state_q [NCH];
    ch_state_e             state_d [NCH];
    logic [NCH-1:0]        ovr_q;
    logic [NCH-1:0]        ovr_d;
    logic [SRW-1:0]        shreg_q;
    logic [SRW-1:0]        shreg_d;
    logic [WIDTH-1:0]      upd_data_q;
    logic [WIDTH-1:0]      upd_data_d;

    generate
        if (SYNC != 0) begin : g_sync
            jtag_sync u_sync (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .d_i    (scan_in_i),
                .q_o    (tdi_s)
            );
        end else begin : g_nosync
            assign tdi_s = scan_in_i;
        end
    endgenerate

    // Decode the active TAP operation (capture > shift > update) and the selected channel.
    always_comb begin
        sel_ok_s   = ({1'b0, sel_i} < NCH_L);
        do_cap_s   = enable_i & capture_dr_i;
        do_shift_s = enable_i & ~capture_dr_i & shift_dr_i;
        do_upd_s   = enable_i & ~capture_dr_i & ~shift_dr_i & update_dr_i & sel_ok_s;
        sel_hot_s  = '0;
        cap_sel_s  = '0;
        ovr_sel_s  = 1'b0;
        vld_sel_s  = 1'b0;
        // Out-of-range selects leave every term zero, so capture reads all-zero.
        for (int c = 0; c < NCH; c++) begin
            sel_hot_s[c] = (sel_i == SW'(c));
            cap_sel_s    = cap_sel_s | (cap_data_i[c] & {WIDTH{sel_hot_s[c]}});
            ovr_sel_s    = ovr_sel_s | (ovr_q[c] & sel_hot_s[c]);
            vld_sel_s    = vld_sel_s | ((state_q[c] == CH_PEND) & sel_hot_s[c]);
        end
    end

    // Per-channel handshake state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= CH_IDLE;
            end
        end else begin
            state_q <= state_d;
        end
    end

    // Per-channel next state: an update always leaves the channel pending
    // (accepted or overrun); a handshake alone returns it to idle.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            upd_ch_s[c] = do_upd_s & sel_hot_s[c];
            state_d[c]  = state_q[c];
            case (state_q[c])
                CH_IDLE: begin
                    if (upd_ch_s[c]) begin
                        state_d[c] = CH_PEND;
                    end else begin
                        state_d[c] = CH_IDLE;
                    end
                end
                CH_PEND: begin
                    if (upd_ch_s[c]) begin
                        state_d[c] = CH_PEND;
                    end else if (upd_ready_i[c]) begin
                        state_d[c] = CH_IDLE;
                    end else begin
                        state_d[c] = CH_PEND;
                    end
                end
                default: begin
                    state_d[c] = CH_IDLE;
                end
            endcase
        end
    end

    // Per-channel outputs: valid flag, payload acceptance and overrun detection.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            upd_valid_o[c] = (state_q[c] == CH_PEND);
            accept_s[c]    = upd_ch_s[c] & ((state_q[c] == CH_IDLE) | upd_ready_i[c]);
            ovr_set_s[c]   = upd_ch_s[c] & (state_q[c] == CH_PEND) & ~upd_ready_i[c];
        end
    end

    // Next scan register, sticky overrun flags and update payload.
    always_comb begin
        shreg_d    = shreg_q;
        ovr_d      = ovr_q;
        upd_data_d = upd_data_q;
        if (do_cap_s) begin
            shreg_d = {cap_sel_s, ovr_sel_s, vld_sel_s};
            ovr_d   = ovr_q & ~sel_hot_s;
        end else if (do_shift_s) begin
            shreg_d = {tdi_s, shreg_q[SRW-1:1]};
        end else begin
            shreg_d = shreg_q;
        end
        // Capture and update are exclusive, so set and clear never collide.
        ovr_d = ovr_d | ovr_set_s;
        if (|accept_s) begin
            upd_data_d = shreg_q[SRW-1:STAT_BITS];
        end else begin
            upd_data_d = upd_data_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shreg_q    <= '0;
            ovr_q      <= '0;
            upd_data_q <= '0;
        end else begin
            shreg_q    <= shreg_d;
            ovr_q      <= ovr_d;
            upd_data_q <= upd_data_d;
        end
    end

    assign scan_out_o = shreg_q[STAT_BUSY];
    assign upd_data_o = upd_data_q;

endmodule

// File: tb/tb_jtag_dr_hs.sv
// Self-checking bench for jtag_dr_hs. Two instances share the stimulus:
// dut_a (WIDTH=8, NCH=2, SYNC=0) and dut_b (WIDTH=8, NCH=3, SYNC=1, so an
// out-of-range select exists). Expected values go into a scoreboard queue
// as stimulus is driven and are popped when the outputs are sampled.
module tb_jtag_dr_hs;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cap;
    logic             sh;
    logic             upd;
    logic             tdi;
    logic [1:0]       sel_b;
    logic [0:0]       sel_a;
    logic [2:0]       rdy_b;
    logic [1:0]       rdy_a;
    logic [2:0][7:0]  cap_b;
    logic [1:0][7:0]  cap_a;
    logic             tdo_a;
    logic             tdo_b;
    logic [7:0]       data_a;
    logic [7:0]       data_b;
    logic [1:0]       vld_a;
    logic [2:0]       vld_b;

    int               checks   = 0;
    int               failures = 0;
    logic [31:0]      exp_q [$];
    bit               check_a  = 1'b1;

    assign sel_a = sel_b[0:0];
    assign rdy_a = rdy_b[1:0];
    assign cap_a = cap_b[1:0];

    always #5 clk = ~clk;

    jtag_dr_hs #(.WIDTH(8), .NCH(2), .SYNC(0)) dut_a (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (en),
        .capture_dr_i (cap),
        .shift_dr_i   (sh),
        .update_dr_i  (upd),
        .sel_i        (sel_a),
        .scan_in_i    (tdi),
        .scan_out_o   (tdo_a),
        .cap_data_i   (cap_a),
        .upd_data_o   (data_a),
        .upd_valid_o  (vld_a),
        .upd_ready_i  (rdy_a)
    );

    jtag_dr_hs #(.WIDTH(8), .NCH(3), .SYNC(1)) dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (en),
        .capture_dr_i (cap),
        .shift_dr_i   (sh),
        .update_dr_i  (upd),
        .sel_i        (sel_b),
        .scan_in_i    (tdi),
        .scan_out_o   (tdo_b),
        .cap_data_i   (cap_b),
        .upd_data_o   (data_b),
        .upd_valid_o  (vld_b),
        .upd_ready_i  (rdy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the next expectation and compare it against both instances.
    task automatic pop_cmp(input string tag, input logic [31:0] obs_a, input logic [31:0] obs_b);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        if (check_a) begin
            chk({tag, "_a"}, obs_a, e);
        end
        chk({tag, "_b"}, obs_b, e);
    endtask

    // One TCK edge: TDI settles for two clocks (synchroniser depth) before
    // the strobe; ready is applied only in the strobe cycle.
    task automatic strobe(input logic c, input logic s, input logic u,
                          input logic tdi_v, input logic [2:0] rdy_v);
        tdi = tdi_v;
        repeat (2) @(negedge clk);
        en = 1'b1; cap = c; sh = s; upd = u; rdy_b = rdy_v;
        @(negedge clk);
        en = 1'b0; cap = 1'b0; sh = 1'b0; upd = 1'b0; rdy_b = 3'b000;
    endtask

    // Capture, then shift in din (LSB first) while checking the captured stream on TDO.
    task automatic dr_scan(input logic [9:0] exp_cap, input logic [9:0] din, input string tag);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(32'(exp_cap[i]));
        end
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        pop_cmp({tag, "_tdo0"}, 32'(tdo_a), 32'(tdo_b));
        for (int i = 0; i < 10; i++) begin
            strobe(1'b0, 1'b1, 1'b0, din[i], 3'b000);
            if (i < 9) begin
                pop_cmp({tag, "_tdo"}, 32'(tdo_a), 32'(tdo_b));
            end
        end
    endtask

    task automatic do_update(input logic [2:0] rdy_v, input logic [7:0] exp_data,
                             input logic [2:0] exp_vld, input string tag);
        exp_q.push_back(32'(exp_data));
        exp_q.push_back(32'(exp_vld));
        strobe(1'b0, 1'b0, 1'b1, 1'b0, rdy_v);
        pop_cmp({tag, "_data"}, 32'(data_a), 32'(data_b));
        pop_cmp({tag, "_vld"}, 32'(vld_a), 32'(vld_b));
    endtask

    // Drive ready for one idle cycle and check the resulting valid vector.
    task automatic handshake(input logic [2:0] rdy_v, input logic [2:0] exp_vld, input string tag);
        exp_q.push_back(32'(exp_vld));
        rdy_b = rdy_v;
        @(negedge clk);
        rdy_b = 3'b000;
        pop_cmp(tag, 32'(vld_a), 32'(vld_b));
    endtask

    task automatic check_all_zero(input string tag);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        pop_cmp({tag, "_tdo"}, 32'(tdo_a), 32'(tdo_b));
        pop_cmp({tag, "_data"}, 32'(data_a), 32'(data_b));
        pop_cmp({tag, "_vld"}, 32'(vld_a), 32'(vld_b));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; cap = 1'b0; sh = 1'b0; upd = 1'b0; tdi = 1'b0;
        sel_b = 2'd0; rdy_b = 3'b000;
        cap_b[0] = 8'h5A; cap_b[1] = 8'hA5; cap_b[2] = 8'hC3;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Channel 1 capture of 0xA5 with clean status; load 0x3C with junk status bits.
        sel_b = 2'd1;
        dr_scan({8'hA5, 2'b00}, {8'h3C, 2'b11}, "cap1");

        // Accepted update on channel 0.
        sel_b = 2'd0;
        do_update(3'b000, 8'h3C, 3'b001, "upd0");

        // Pending channel shows busy; a second update without ready overruns.
        dr_scan({8'h5A, 2'b01}, {8'h55, 2'b00}, "busy");
        do_update(3'b000, 8'h3C, 3'b001, "ovr_upd");
        dr_scan({8'h5A, 2'b11}, {8'h96, 2'b10}, "ovr_cap");
        dr_scan({8'h5A, 2'b01}, {8'h96, 2'b00}, "ovr_clr");

        // Update coinciding with the handshake is accepted, valid stays, no overrun.
        do_update(3'b001, 8'h96, 3'b001, "hs_upd");
        dr_scan({8'h5A, 2'b01}, {8'h81, 2'b00}, "no_ovr");
        handshake(3'b001, 3'b000, "hs_clr0");

        // Channel 1 is independent of channel 0.
        sel_b = 2'd1;
        do_update(3'b000, 8'h81, 3'b010, "upd1");
        handshake(3'b010, 3'b000, "hs_clr1");

        // Out-of-range select on the 3-channel instance: zero capture, ignored update.
        check_a = 1'b0;
        sel_b = 2'd3;
        dr_scan(10'h000, {8'hE7, 2'b00}, "oor_cap");
        do_update(3'b000, 8'h81, 3'b000, "oor_upd");

        // Reset mid-shift with an update pending discards everything.
        sel_b = 2'd0;
        do_update(3'b000, 8'hE7, 3'b001, "pre_rst");
        strobe(1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
        strobe(1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
        check_a = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_q.push_back(32'd0);
            pop_cmp("post_rst_vld", 32'(vld_a), 32'(vld_b));
        end

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
